// File: rtl/axi_lite_regfile_pkg.sv
// Shared constants and types for the AXI-Lite control/status register file.
// Register indices, response codes, CTRL bit positions and access kinds.
package axi_lite_regfile_pkg;

    localparam int IDX_W = 5;

    localparam logic [IDX_W-1:0] IDX_CTRL     = 5'd0;
    localparam logic [IDX_W-1:0] IDX_STATUS   = 5'd1;
    localparam logic [IDX_W-1:0] IDX_COUNTER  = 5'd2;
    localparam logic [IDX_W-1:0] IDX_ID       = 5'd3;
    localparam logic [IDX_W-1:0] IDX_SCRATCH0 = 5'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_CNT_EN      = 0;
    localparam int CTRL_CNT_CLR     = 1;
    localparam int CTRL_IRQ_MASK_LO = 8;
    localparam int CTRL_IRQ_MASK_HI = 15;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_RW   = 2'd1,
        ACC_W1C  = 2'd2,
        ACC_RO   = 2'd3
    } access_t;

endpackage

// File: rtl/axi_lite_regfile_addr_decode.sv
// Combinational byte-address decode: word index, access kind and error flag.
// Misaligned or out-of-map addresses report ACC_NONE with err set.
module regfile_addr_decode
    import axi_lite_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SCRATCH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output access_t               acc,
    output logic                  err
);

    localparam int LSB       = $clog2(DATA_WIDTH / 8);
    localparam int MAP_WORDS = int'(IDX_SCRATCH0) + NUM_SCRATCH;

    logic [ADDR_WIDTH-1:0] word;
    logic                  misaligned;
    logic                  in_range;

    assign word       = addr >> LSB;
    assign misaligned = (addr[LSB-1:0] != '0);
    assign in_range   = (word < ADDR_WIDTH'(MAP_WORDS));

    always_comb begin
        idx = word[IDX_W-1:0];
        acc = ACC_NONE;
        err = 1'b1;
        if (!misaligned && in_range) begin
            err = 1'b0;
            case (idx)
                IDX_CTRL:             acc = ACC_RW;
                IDX_STATUS:           acc = ACC_W1C;
                IDX_COUNTER, IDX_ID:  acc = ACC_RO;
                default:              acc = ACC_RW;
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// Control/status register file behind the AXI-Lite slave's local bus:
// CTRL, sticky STATUS, cycle COUNTER, constant ID and scratch words.
module axi_lite_regfile
    import axi_lite_regfile_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [31:0] ID_VALUE    = 32'h5A11_0001
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   user_wr_addr,
    input  logic [DATA_WIDTH-1:0]   user_wr_data,
    input  logic [DATA_WIDTH/8-1:0] user_wr_strb,
    input  logic                    user_wr_en,
    output logic [1:0]              user_wr_resp,
    input  logic [ADDR_WIDTH-1:0]   user_rd_addr,
    input  logic                    user_rd_en,
    output logic [DATA_WIDTH-1:0]   user_rd_data,
    output logic [1:0]              user_rd_resp,
    input  logic [7:0]              hw_event,
    output logic [DATA_WIDTH-1:0]   ctrl_out,
    output logic                    irq
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] CLR_BIT = DATA_WIDTH'(1) << CTRL_CNT_CLR;

    logic [IDX_W-1:0]      wr_idx, rd_idx;
    access_t               wr_acc, rd_acc;
    logic                  wr_err, rd_err;
    logic                  wr_ok, cnt_clr;
    logic [DATA_WIDTH-1:0] wmask, rd_next;
    logic [7:0]            status_clr;

    logic [DATA_WIDTH-1:0] ctrl_q;
    logic [7:0]            status_q;
    logic [DATA_WIDTH-1:0] counter_q;
    logic [DATA_WIDTH-1:0] scratch_q [NUM_SCRATCH];

    regfile_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SCRATCH(NUM_SCRATCH)
    ) u_wr_decode (
        .addr(user_wr_addr),
        .idx (wr_idx),
        .acc (wr_acc),
        .err (wr_err)
    );

    regfile_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SCRATCH(NUM_SCRATCH)
    ) u_rd_decode (
        .addr(user_rd_addr),
        .idx (rd_idx),
        .acc (rd_acc),
        .err (rd_err)
    );

    // Writes are accepted only for RW/W1C targets; RO and decode errors are SLVERR.
    assign user_wr_resp = (!wr_err && (wr_acc == ACC_RW || wr_acc == ACC_W1C)) ? RESP_OKAY
                                                                                : RESP_SLVERR;
    assign wr_ok      = user_wr_en && (user_wr_resp == RESP_OKAY);
    assign cnt_clr    = wr_ok && (wr_idx == IDX_CTRL) && user_wr_data[CTRL_CNT_CLR] && user_wr_strb[0];
    assign status_clr = (wr_ok && wr_idx == IDX_STATUS) ? (user_wr_data[7:0] & wmask[7:0]) : '0;
    assign ctrl_out   = ctrl_q;

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            wmask[8*i +: 8] = {8{user_wr_strb[i]}};
        end
    end

    always_comb begin
        rd_next = '0;
        if (!rd_err) begin
            case (rd_idx)
                IDX_CTRL:    rd_next = ctrl_q;
                IDX_STATUS:  rd_next = DATA_WIDTH'(status_q);
                IDX_COUNTER: rd_next = counter_q;
                IDX_ID:      rd_next = DATA_WIDTH'(ID_VALUE);
                default: begin
                    for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                        if (rd_idx == IDX_W'(int'(IDX_SCRATCH0) + i)) rd_next = scratch_q[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_q    <= '0;
            status_q  <= '0;
            counter_q <= '0;
            irq       <= 1'b0;
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else begin
            if (wr_ok && wr_idx == IDX_CTRL)
                ctrl_q <= ((ctrl_q & ~wmask) | (user_wr_data & wmask)) & ~CLR_BIT;
            // Event set wins over a same-cycle W1C clear.
            status_q <= (status_q & ~status_clr) | hw_event;
            if (cnt_clr)
                counter_q <= '0;
            else if (ctrl_q[CTRL_CNT_EN])
                counter_q <= counter_q + 1'b1;
            irq <= |(status_q & ctrl_q[CTRL_IRQ_MASK_HI:CTRL_IRQ_MASK_LO]);
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_ok && wr_idx == IDX_W'(int'(IDX_SCRATCH0) + i))
                    scratch_q[i] <= (scratch_q[i] & ~wmask) | (user_wr_data & wmask);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            user_rd_data <= '0;
            user_rd_resp <= RESP_OKAY;
        end else if (user_rd_en) begin
            user_rd_data <= rd_next;
            user_rd_resp <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed self-checking bench for axi_lite_regfile; read results are
// checked against a scoreboard queue filled when each read is issued.
module tb_axi_lite_regfile;

    localparam logic [31:0] ID = 32'h5A11_0001;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data, ctrl_out;
    logic [3:0]  wr_strb;
    logic        wr_en, rd_en, irq;
    logic [1:0]  wr_resp, rd_resp;
    logic [7:0]  hw_event;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    always #5 aclk = ~aclk;

    axi_lite_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_SCRATCH(4),
        .ID_VALUE   (ID)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .user_wr_addr(wr_addr),
        .user_wr_data(wr_data),
        .user_wr_strb(wr_strb),
        .user_wr_en  (wr_en),
        .user_wr_resp(wr_resp),
        .user_rd_addr(rd_addr),
        .user_rd_en  (rd_en),
        .user_rd_data(rd_data),
        .user_rd_resp(rd_resp),
        .hw_event    (hw_event),
        .ctrl_out    (ctrl_out),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_data"}, rd_data, e.data);
            chk({e.tag, "_resp"}, 32'(rd_resp), 32'(e.resp));
        end
    endtask

    // Tasks start and end at a falling edge; the DUT samples on the rising edge between.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_d, input logic [1:0] exp_r);
        sb.push_back('{tag, exp_d, exp_r});
        rd_addr = addr;
        rd_en   = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
        pop_check();
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        wr_addr = addr;
        wr_data = data;
        wr_strb = strb;
        wr_en   = 1'b1;
        #1;
        chk({tag, "_wresp"}, 32'(wr_resp), 32'(exp_resp));
        @(negedge aclk);
        wr_en = 1'b0;
    endtask

    initial begin
        aresetn  = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
        wr_en    = 1'b0;
        rd_addr  = '0;
        rd_en    = 1'b0;
        hw_event = '0;
        repeat (2) @(negedge aclk);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_resp", 32'(rd_resp), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_ctrl_out", ctrl_out, 32'h0);
        aresetn = 1'b1;
        @(negedge aclk);

        do_read("id", 32'h0C, ID, 2'b00);
        do_read("counter_rst", 32'h08, 32'h0, 2'b00);

        do_write("scr0_w1", 32'h10, 32'hDEADBEEF, 4'b0101, 2'b00);
        do_read("scr0_r1", 32'h10, 32'h00AD00EF, 2'b00);
        do_write("scr0_w2", 32'h10, 32'h11223344, 4'b1010, 2'b00);
        do_read("scr0_r2", 32'h10, 32'h11AD33EF, 2'b00);
        do_write("scr3_w", 32'h1C, 32'hCAFEF00D, 4'b1111, 2'b00);
        do_read("scr3_r", 32'h1C, 32'hCAFEF00D, 2'b00);

        // Same-cycle write and read of one register: read sees the old value.
        do_write("scr1_w", 32'h14, 32'hA5A5A5A5, 4'b1111, 2'b00);
        sb.push_back('{"scr1_rw_same", 32'hA5A5A5A5, 2'b00});
        wr_addr = 32'h14;
        wr_data = 32'h12345678;
        wr_strb = 4'b1111;
        wr_en   = 1'b1;
        rd_addr = 32'h14;
        rd_en   = 1'b1;
        @(negedge aclk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        pop_check();
        do_read("scr1_after", 32'h14, 32'h12345678, 2'b00);

        do_write("ctrl_en", 32'h00, 32'h1, 4'b1111, 2'b00);
        repeat (10) @(negedge aclk);
        do_read("counter_10", 32'h08, 32'd10, 2'b00);
        do_write("ctrl_clr", 32'h00, 32'h3, 4'b1111, 2'b00);
        do_read("counter_clr", 32'h08, 32'd0, 2'b00);
        do_read("ctrl_rd", 32'h00, 32'h1, 2'b00);
        chk("ctrl_out_en", ctrl_out, 32'h1);

        hw_event = 8'h04;
        @(negedge aclk);
        hw_event = 8'h00;
        do_write("ctrl_mask", 32'h00, 32'h0401, 4'b1111, 2'b00);
        chk("irq_lag", 32'(irq), 32'h0);
        @(negedge aclk);
        chk("irq_set", 32'(irq), 32'h1);
        hw_event = 8'h04;
        do_write("status_w1c_held", 32'h04, 32'h4, 4'b1111, 2'b00);
        do_read("status_held", 32'h04, 32'h4, 2'b00);
        hw_event = 8'h00;
        do_write("status_w1c", 32'h04, 32'h4, 4'b1111, 2'b00);
        chk("irq_still", 32'(irq), 32'h1);
        @(negedge aclk);
        chk("irq_clr", 32'(irq), 32'h0);
        do_read("status_clr", 32'h04, 32'h0, 2'b00);

        do_write("ctrl_stop", 32'h00, 32'h2, 4'b1111, 2'b00);
        chk("ctrl_out_stop", ctrl_out, 32'h0);
        do_write("err_counter", 32'h08, 32'hFFFFFFFF, 4'b1111, 2'b10);
        do_write("err_id", 32'h0C, 32'hFFFFFFFF, 4'b1111, 2'b10);
        do_write("err_mis", 32'h12, 32'hFFFFFFFF, 4'b1111, 2'b10);
        do_write("err_mis_hi", 32'h1002, 32'hFFFFFFFF, 4'b1111, 2'b10);
        do_write("err_oor", 32'h20, 32'hFFFFFFFF, 4'b1111, 2'b10);
        do_read("counter_kept", 32'h08, 32'h0, 2'b00);
        do_read("id_kept", 32'h0C, ID, 2'b00);
        do_read("scr0_kept", 32'h10, 32'h11AD33EF, 2'b00);
        do_read("rd_err_mis", 32'h12, 32'h0, 2'b10);
        do_read("rd_err_mis_hi", 32'h1002, 32'h0, 2'b10);
        do_read("rd_err_oor", 32'h20, 32'h0, 2'b10);

        do_write("ctrl_run", 32'h00, 32'h0401, 4'b1111, 2'b00);
        hw_event = 8'h04;
        @(negedge aclk);
        hw_event = 8'h00;
        do_read("id_pre_rst", 32'h0C, ID, 2'b00);
        chk("irq_pre_rst", 32'(irq), 32'h1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_rd_data", rd_data, 32'h0);
        chk("midrst_rd_resp", 32'(rd_resp), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_ctrl_out", ctrl_out, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        do_read("counter_post_rst", 32'h08, 32'h0, 2'b00);
        do_read("status_post_rst", 32'h04, 32'h0, 2'b00);
        do_read("scr0_post_rst", 32'h10, 32'h0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
